// File: rtl/rc_pulse_capture_multi.sv
// Multi-channel RC pulse-width capture.
// Each channel synchronizes its input, samples it on a shared prescaled tick,
// measures the high time between low periods and flags lost (long low) and
// stuck-high signals. All results are registered; o_valid is a one-cycle strobe.
module rc_pulse_capture_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int CLK_DIV  = 50,
    parameter int MIN_HIGH = 500,
    parameter int MAX_HIGH = 4000,
    parameter int MAX_LOW  = 40000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_signal,
    output logic [NUM_CH*CNT_W-1:0] o_pulseWidth,
    output logic [NUM_CH-1:0]       o_valid,
    output logic [NUM_CH-1:0]       o_timeout,
    output logic [NUM_CH-1:0]       o_stuckHigh
);

    localparam int               PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    DIV_LAST   = PW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_HIGH_C = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] MAX_LOW_C  = CNT_W'(MAX_LOW);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_s;
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;

    state_t            state_q    [NUM_CH];
    state_t            state_d    [NUM_CH];
    logic [CNT_W-1:0]  low_cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  low_cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  high_cnt_q [NUM_CH];
    logic [CNT_W-1:0]  high_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  width_q    [NUM_CH];
    logic [CNT_W-1:0]  width_d    [NUM_CH];
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] timeout_q, timeout_d;
    logic [NUM_CH-1:0] stuck_q, stuck_d;

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}}) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    // Shared prescaler tick and the two-stage input synchronizer.
    always_comb begin
        tick_s  = (presc_q == DIV_LAST);
        presc_d = tick_s ? {PW{1'b0}} : presc_q + PW'(1);
        sync1_d = i_signal;
        sync2_d = sync1_q;
    end

    // Per-channel IDLE/LOW/HIGH next-state, counters and result computation.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]    = state_q[i];
            low_cnt_d[i]  = low_cnt_q[i];
            high_cnt_d[i] = high_cnt_q[i];
            width_d[i]    = width_q[i];
            valid_d[i]    = 1'b0;
            timeout_d[i]  = timeout_q[i];
            stuck_d[i]    = stuck_q[i];
            if (tick_s) begin
                case (state_q[i])
                    ST_IDLE: begin
                        // Wait for a low sample so a partial first pulse is never measured.
                        if (!sync2_q[i]) begin
                            state_d[i]   = ST_LOW;
                            low_cnt_d[i] = CNT_ONE;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    ST_LOW: begin
                        if (!sync2_q[i]) begin
                            low_cnt_d[i] = sat_inc(low_cnt_q[i]);
                            if (low_cnt_d[i] > MAX_LOW_C) begin
                                width_d[i]   = {CNT_W{1'b0}};
                                timeout_d[i] = 1'b1;
                            end else begin
                                width_d[i] = width_q[i];
                            end
                        end else begin
                            state_d[i]    = ST_HIGH;
                            high_cnt_d[i] = CNT_ONE;
                            low_cnt_d[i]  = {CNT_W{1'b0}};
                        end
                    end
                    ST_HIGH: begin
                        if (sync2_q[i]) begin
                            high_cnt_d[i] = sat_inc(high_cnt_q[i]);
                            if (high_cnt_d[i] > MAX_HIGH_C) begin
                                width_d[i] = {CNT_W{1'b1}};
                                stuck_d[i] = 1'b1;
                            end else begin
                                width_d[i] = width_q[i];
                            end
                        end else begin
                            // Falling edge: classify the completed high period.
                            state_d[i]    = ST_LOW;
                            low_cnt_d[i]  = CNT_ONE;
                            high_cnt_d[i] = {CNT_W{1'b0}};
                            if (high_cnt_q[i] > MAX_HIGH_C) begin
                                stuck_d[i] = 1'b0;
                            end else if (high_cnt_q[i] >= MIN_HIGH_C) begin
                                width_d[i]   = high_cnt_q[i];
                                valid_d[i]   = 1'b1;
                                timeout_d[i] = 1'b0;
                                stuck_d[i]   = 1'b0;
                            end else begin
                                width_d[i] = width_q[i];
                            end
                        end
                    end
                    default: begin
                        state_d[i]    = ST_IDLE;
                        low_cnt_d[i]  = {CNT_W{1'b0}};
                        high_cnt_d[i] = {CNT_W{1'b0}};
                    end
                endcase
            end else begin
                state_d[i] = state_q[i];
            end
        end
    end

    // State registers with synchronous reset taking priority over any tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q   <= {PW{1'b0}};
            sync1_q   <= {NUM_CH{1'b0}};
            sync2_q   <= {NUM_CH{1'b0}};
            valid_q   <= {NUM_CH{1'b0}};
            timeout_q <= {NUM_CH{1'b0}};
            stuck_q   <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= ST_IDLE;
                low_cnt_q[i]  <= {CNT_W{1'b0}};
                high_cnt_q[i] <= {CNT_W{1'b0}};
                width_q[i]    <= {CNT_W{1'b0}};
            end
        end else begin
            presc_q   <= presc_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            stuck_q   <= stuck_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= state_d[i];
                low_cnt_q[i]  <= low_cnt_d[i];
                high_cnt_q[i] <= high_cnt_d[i];
                width_q[i]    <= width_d[i];
            end
        end
    end

    // Drive the registered results onto the flat output ports.
    always_comb begin
        o_pulseWidth = {(NUM_CH*CNT_W){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            o_pulseWidth[i*CNT_W +: CNT_W] = width_q[i];
        end
        o_valid     = valid_q;
        o_timeout   = timeout_q;
        o_stuckHigh = stuck_q;
    end

endmodule

// File: doc/rc_pulse_capture_multi.md
RC_PULSE_CAPTURE_MULTI -- requirements
Module: rc_pulse_capture_multi

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 4: number of independent RC input channels.
REQ-002 The block SHALL take parameter CNT_W, default 16: width of each per-channel counter and pulse-width result.
REQ-003 The block SHALL take parameter CLK_DIV, default 50: i_clk cycles per sample tick, legal range 1 or more.
REQ-004 The block SHALL take parameter MIN_HIGH, default 500: the shortest accepted pulse, in ticks.
REQ-005 The block SHALL take parameter MAX_HIGH, default 4000: the longest accepted pulse, in ticks, with MAX_HIGH < 2^CNT_W-1.
REQ-006 The block SHALL take parameter MAX_LOW, default 40000: the low-time limit, in ticks, before a channel is declared lost, with MAX_LOW < 2^CNT_W-1.
REQ-007 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port i_signal, input, NUM_CH bits: asynchronous RC pulse inputs, with channel i on bit i.
REQ-010 The block SHALL have port o_pulseWidth, output, NUM_CH*CNT_W bits: the last result for channel i, on bits [i*CNT_W +: CNT_W].
REQ-011 The block SHALL have port o_valid, output, NUM_CH bits: a one-cycle strobe per channel when a new accepted width is written.
REQ-012 The block SHALL have port o_timeout, output, NUM_CH bits: a level flag per channel meaning the signal has been low longer than MAX_LOW.
REQ-013 The block SHALL have port o_stuckHigh, output, NUM_CH bits: a level flag per channel meaning the signal has been high longer than MAX_HIGH.

Function
REQ-014 Each i_signal bit SHALL pass through a 2-flop synchronizer before any use.
REQ-015 One shared prescaler SHALL count 0..CLK_DIV-1 and assert an internal tick for one cycle when it equals CLK_DIV-1, then wrap to 0.
REQ-016 Channels SHALL update state and counters only on tick cycles, sampling the synchronized input; o_valid SHALL be the only output pulsed from tick logic.
REQ-017 Each channel SHALL run its own state machine with states IDLE, LOW and HIGH, and SHALL enter IDLE on reset.
REQ-018 In IDLE, a tick with a low sample SHALL move the channel to LOW with the low counter set to 1; a high sample SHALL leave it in IDLE, so a partial first pulse is never measured.
REQ-019 In LOW with a low sample, the low counter SHALL increment, saturating at all-ones; once it exceeds MAX_LOW, o_pulseWidth SHALL be 0 and o_timeout SHALL be 1.
REQ-020 In LOW with a high sample, the channel SHALL move to HIGH with the high counter set to 1 and the low counter cleared; o_timeout SHALL stay unchanged until the next accepted pulse.
REQ-021 In HIGH with a high sample, the high counter SHALL increment, saturating at all-ones; once it exceeds MAX_HIGH, o_pulseWidth SHALL be all-ones and o_stuckHigh SHALL be 1.
REQ-022 In HIGH with a low sample (falling edge), the channel SHALL move to LOW with the low counter set to 1.
REQ-023 On that falling edge, if MIN_HIGH <= high count <= MAX_HIGH, the channel SHALL write the high count to o_pulseWidth, pulse o_valid, and clear o_timeout and o_stuckHigh.
REQ-024 On that falling edge, if high count < MIN_HIGH (glitch), o_pulseWidth and all flags SHALL be unchanged and o_valid SHALL NOT pulse.
REQ-025 On that falling edge, if high count > MAX_HIGH, the channel SHALL clear o_stuckHigh, leave o_pulseWidth at all-ones, and SHALL NOT pulse o_valid.
REQ-026 Latency SHALL be: an input edge is synchronized after 2 cycles, seen at the next tick, and reflected in the outputs on the cycle after that tick.
REQ-027 o_valid SHALL be high for exactly one i_clk cycle per accepted pulse and never two cycles in a row.
REQ-028 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be handled in the same tick with no priority or loss between them.
REQ-029 High count of exactly MIN_HIGH and exactly MAX_HIGH SHALL be accepted; MAX_HIGH+1 SHALL set o_stuckHigh; a low count of MAX_LOW+1 SHALL set o_timeout.

Reset
REQ-030 When i_rst=1 at a clock edge, the block SHALL clear the prescaler, synchronizers and all counters, and place every channel in IDLE.
REQ-031 When i_rst=1 at a clock edge, o_pulseWidth, o_valid, o_timeout and o_stuckHigh SHALL all be 0 on the following cycle.
REQ-032 Reset SHALL take priority over a coincident tick or edge; a pulse in flight at reset SHALL be discarded with no o_valid.

Verification (NUM_CH=2, CNT_W=16, CLK_DIV=4, MIN_HIGH=2, MAX_HIGH=20, MAX_LOW=50)
REQ-033 The bench SHALL check: ch0 low for 10 ticks, high for 15 ticks, then low -> o_pulseWidth[15:0]=15, o_valid[0] high for 1 cycle, ch1 outputs unchanged.
REQ-034 The bench SHALL check: ch0 high 1 tick between lows -> no o_valid and o_pulseWidth unchanged; high for exactly 2 ticks and for exactly 20 ticks -> each accepted with widths 2 and 20.
REQ-035 The bench SHALL check: ch0 high for 25 ticks -> o_stuckHigh[0]=1 and width 16'hFFFF after tick 21; on the fall -> o_stuckHigh[0]=0, no o_valid, width stays 16'hFFFF.
REQ-036 The bench SHALL check: ch1 held low for 60 ticks -> o_timeout[1]=1 and width 0 after tick 51; a following 10-tick pulse -> width 10, o_valid[1] pulse, o_timeout[1]=0.
REQ-037 The bench SHALL check: both channels fall on the same tick with widths 5 and 7 -> both o_valid bits pulse in the same cycle with correct widths.
REQ-038 The bench SHALL check: i_rst asserted mid-pulse on ch0 -> all outputs 0 on the next cycle, and a high input at release is ignored until a low is sampled.
